// File: rtl/issue_ctrl.sv
// issue_ctrl: circular instruction queue between fetch and decode, issuing in order when ROB/RS/LSB have room.
module issue_ctrl #(
    parameter int QUE_BIT = 4,
    parameter int DAT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush_i,
    input  logic             if_en_i,
    input  logic             if_ic_i,
    input  logic [DAT_W-1:0] if_ins_i,
    input  logic [DAT_W-1:0] if_pc_i,
    input  logic             if_pbr_i,
    output logic             if_full_o,
    input  logic             rob_full_i,
    input  logic             rs_full_i,
    input  logic             lsb_full_i,
    output logic             dec_en_o,
    output logic             dec_ic_o,
    output logic [DAT_W-1:0] dec_ins_o,
    output logic [DAT_W-1:0] dec_pc_o,
    output logic             dec_pbr_o
);
    localparam int DEPTH = 1 << QUE_BIT;
    localparam logic [QUE_BIT:0] FULL_CNT = (QUE_BIT+1)'(DEPTH);
    localparam logic [QUE_BIT:0] NEAR_CNT = (QUE_BIT+1)'(DEPTH - 1);

    logic [QUE_BIT-1:0] head, tail;
    logic [QUE_BIT:0]   count;
    logic               q_ic  [DEPTH];
    logic [DAT_W-1:0]   q_ins [DEPTH];
    logic [DAT_W-1:0]   q_pc  [DEPTH];
    logic               q_pbr [DEPTH];
    logic               q_mem [DEPTH];
    logic               dec_en_r, pre_mem, issue, push;

    // loads/stores go to the LSB, everything else to the RS; C.LW/C.SW/C.LWSP/C.SWSP all have ins[0]=0, funct3=x10
    always_comb begin
        pre_mem   = if_ic_i ? (!if_ins_i[0] && if_ins_i[14:13] == 2'b10)
                            : (if_ins_i[6:0] == 7'b0000011 || if_ins_i[6:0] == 7'b0100011);
        issue     = count != '0 && !rob_full_i && (q_mem[head] ? !lsb_full_i : !rs_full_i);
        push      = if_en_i && (count != FULL_CNT || issue);
        if_full_o = count >= NEAR_CNT;
        dec_en_o  = dec_en_r & en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            dec_en_r  <= 1'b0;
            dec_ic_o  <= 1'b0;
            dec_ins_o <= '0;
            dec_pc_o  <= '0;
            dec_pbr_o <= 1'b0;
        end else if (en) begin
            if (flush_i) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                dec_en_r <= 1'b0;
            end else begin
                dec_en_r <= issue;
                if (issue) begin
                    head      <= head + 1'b1;
                    dec_ic_o  <= q_ic[head];
                    dec_ins_o <= q_ins[head];
                    dec_pc_o  <= q_pc[head];
                    dec_pbr_o <= q_pbr[head];
                end
                if (push) tail <= tail + 1'b1;
                count <= count + (QUE_BIT+1)'(push) - (QUE_BIT+1)'(issue);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && !flush_i && push) begin
            q_ic[tail]  <= if_ic_i;
            q_ins[tail] <= if_ins_i;
            q_pc[tail]  <= if_pc_i;
            q_pbr[tail] <= if_pbr_i;
            q_mem[tail] <= pre_mem;
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: cycle-level queue model; entries queued at push, popped and compared when the DUT issues.
module tb_issue_ctrl;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b1, flush_i = 1'b0;
    logic        if_en_i = 1'b0, if_ic_i = 1'b0, if_pbr_i = 1'b0;
    logic [31:0] if_ins_i = '0, if_pc_i = '0;
    logic        rob_full_i = 1'b0, rs_full_i = 1'b0, lsb_full_i = 1'b0;
    logic        if_full_o, dec_en_o, dec_ic_o, dec_pbr_o;
    logic [31:0] dec_ins_o, dec_pc_o;

    typedef struct { logic ic; logic [31:0] ins; logic [31:0] pc; logic pbr; } ent_t;
    ent_t qm[$];
    ent_t last;
    bit   mden;
    int   vectors = 0, errors = 0;

    localparam logic [31:0] ADDI = 32'h00100093, LW = 32'h00002083, ADD = 32'h002081b3;
    localparam logic [31:0] SW = 32'h00112023, BEQ = 32'h00208063;
    logic [31:0] i_tab [5] = '{ADDI, LW, SW, ADD, BEQ};
    logic [31:0] c_tab [7] = '{32'h4108, 32'hc10c, 32'h0505, 32'h4082, 32'hc006, 32'ha001, 32'h4505};

    issue_ctrl #(.QUE_BIT(4), .DAT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
        .if_en_i(if_en_i), .if_ic_i(if_ic_i), .if_ins_i(if_ins_i), .if_pc_i(if_pc_i),
        .if_pbr_i(if_pbr_i), .if_full_o(if_full_o),
        .rob_full_i(rob_full_i), .rs_full_i(rs_full_i), .lsb_full_i(lsb_full_i),
        .dec_en_o(dec_en_o), .dec_ic_o(dec_ic_o), .dec_ins_o(dec_ins_o),
        .dec_pc_o(dec_pc_o), .dec_pbr_o(dec_pbr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_mem(input ent_t e);
        if (!e.ic) return e.ins[6:0] == 7'h03 || e.ins[6:0] == 7'h23;
        return (e.ins[1:0] == 2'b00 || e.ins[1:0] == 2'b10) &&
               (e.ins[15:13] == 3'b010 || e.ins[15:13] == 3'b110);
    endfunction

    task automatic model_reset();
        qm.delete();
        mden = 0;
        last = '{ic: 1'b0, ins: 32'h0, pc: 32'h0, pbr: 1'b0};
    endtask

    task automatic model_edge();
        bit iss, ok;
        if (rst || !en) return;
        iss = qm.size() > 0 && !rob_full_i && (is_mem(qm[0]) ? !lsb_full_i : !rs_full_i);
        if (flush_i) begin
            qm.delete();
            mden = 0;
        end else begin
            ok   = if_en_i && (qm.size() < 16 || iss);
            mden = iss;
            if (iss) last = qm.pop_front();
            if (ok) qm.push_back('{ic: if_ic_i, ins: if_ins_i, pc: if_pc_i, pbr: if_pbr_i});
        end
    endtask

    task automatic compare();
        check("dec_en", 64'(dec_en_o), 64'(en && mden));
        check("if_full", 64'(if_full_o), 64'(qm.size() >= 15));
        check("dec_pc", 64'(dec_pc_o), 64'(last.pc));
        check("dec_ins", 64'(dec_ins_o), 64'(last.ins));
        check("dec_ic_pbr", 64'({dec_ic_o, dec_pbr_o}), 64'({last.ic, last.pbr}));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push1(input logic ic, input logic [31:0] ins, input logic [31:0] pc);
        if_en_i = 1'b1; if_ic_i = ic; if_ins_i = ins; if_pc_i = pc; if_pbr_i = pc[2];
        tick();
        if_en_i = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_dec_en", 64'(dec_en_o), 64'(0));
        check("rst_full", 64'(if_full_o), 64'(0));
        check("rst_dec_pc", 64'(dec_pc_o), 64'(0));
        check("rst_dec_ins", 64'(dec_ins_o), 64'(0));

        // three ADDIs stream straight through, one cycle behind the pushes
        push1(0, ADDI, 32'h0); push1(0, ADDI, 32'h4); push1(0, ADDI, 32'h8);
        check("stream_pc4", 64'(dec_pc_o), 64'(32'h4));
        idle(3);

        // LW goes with RS full; ADD blocks the LW behind it until RS frees
        rs_full_i = 1'b1;
        push1(0, LW, 32'h10); push1(0, ADD, 32'h14); push1(0, LW, 32'h18);
        idle(3);
        rs_full_i = 1'b0;
        idle(3);

        // fill past capacity with everything blocked, then drain across the wrap
        rob_full_i = 1'b1;
        for (int i = 0; i < 17; i++) push1(0, (i % 2) ? SW : ADDI, 32'h100 + 32'(i * 4));
        check("full_held", 64'(if_full_o), 64'(1));
        rob_full_i = 1'b0;
        idle(18);

        // C.LW waits on the LSB; C.ADDI ignores LSB pressure
        lsb_full_i = 1'b1;
        push1(1, 32'h4108, 32'h200);
        idle(2);
        lsb_full_i = 1'b0;
        tick();
        lsb_full_i = 1'b1;
        push1(1, 32'h0505, 32'h202);
        idle(2);
        lsb_full_i = 1'b0;

        // flush with a concurrent push discards both
        rob_full_i = 1'b1;
        for (int i = 0; i < 5; i++) push1(0, ADDI, 32'h300 + 32'(i * 4));
        flush_i = 1'b1;
        push1(0, ADD, 32'h400);
        flush_i = 1'b0;
        rob_full_i = 1'b0;
        idle(3);

        // stall: no issue while en=0, resumes immediately after
        rob_full_i = 1'b1;
        for (int i = 0; i < 3; i++) push1(0, ADDI, 32'h500 + 32'(i * 4));
        rob_full_i = 1'b0;
        en = 1'b0;
        idle(3);
        en = 1'b1;
        tick();
        check("resume_pc", 64'(dec_pc_o), 64'(32'h500));
        idle(3);

        for (int i = 0; i < 400; i++) begin
            en         = ($urandom % 8) != 0;
            flush_i    = ($urandom % 40) == 0;
            if_en_i    = ($urandom % 3) != 0;
            if_ic_i    = $urandom % 2;
            if_ins_i   = if_ic_i ? c_tab[$urandom % 7] : i_tab[$urandom % 5];
            if_pc_i    = $urandom;
            if_pbr_i   = $urandom % 2;
            rob_full_i = ($urandom % 5) == 0;
            rs_full_i  = ($urandom % 3) == 0;
            lsb_full_i = ($urandom % 3) == 0;
            tick();
        end
        en = 1'b1; flush_i = 1'b0; if_en_i = 1'b0;
        rob_full_i = 1'b0; rs_full_i = 1'b0; lsb_full_i = 1'b0;
        idle(20);

        // asynchronous reset lands between edges with a nearly full queue
        rob_full_i = 1'b1;
        for (int i = 0; i < 15; i++) push1(0, ADDI, 32'h600 + 32'(i * 4));
        #2 rst = 1'b1;
        #1;
        check("arst_full", 64'(if_full_o), 64'(0));
        check("arst_dec_en", 64'(dec_en_o), 64'(0));
        check("arst_dec_pc", 64'(dec_pc_o), 64'(0));
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        rob_full_i = 1'b0;
        push1(0, ADDI, 32'h700);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Instruction queue and issue sequencer between ins_fetch and decoder.
- Buffers fetched instructions (RV32I or RV32C) in a circular FIFO and releases at most one per cycle to the decoder.
- Issue is gated on ROB, RS and LSB availability using a pre-decoded destination class, and the queue is flushed on ROB clear (branch mispredict).
- Back-pressures ins_fetch through a full flag with one slot of slack.

Parameters:
QUE_BIT, 4, log2 of queue depth (DEPTH = 2^QUE_BIT = 16)
DAT_W, 32, instruction/PC width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
en  input  1  global ready; 0 freezes all state
flush_i  input  1  ROB clear; discard queue and in-flight issue
if_en_i  input  1  fetch push strobe
if_ic_i  input  1  0 = RV32I, 1 = RV32C
if_ins_i  input  DAT_W  instruction (RV32C in [15:0])
if_pc_i  input  DAT_W  instruction PC
if_pbr_i  input  1  predicted taken
if_full_o  output  1  queue nearly full; fetch must stop pushing
rob_full_i  input  1  ROB cannot accept this cycle
rs_full_i  input  1  RS cannot accept this cycle
lsb_full_i  input  1  LSB cannot accept this cycle
dec_en_o  output  1  issue strobe to decoder (one cycle per instruction)
dec_ic_o  output  1  issued instruction format
dec_ins_o  output  DAT_W  issued instruction
dec_pc_o  output  DAT_W  issued PC
dec_pbr_o  output  1  issued prediction bit

Behaviour:
- Storage: DEPTH entries of {ic, ins, pc, pbr, mem}. Pointers head/tail are QUE_BIT wide and wrap modulo DEPTH. count is QUE_BIT+1 wide, range 0..DEPTH.
- Reset (async, rst=1): head = tail = count = 0. dec_en_o = 0. dec_ic_o, dec_ins_o, dec_pc_o and dec_pbr_o are all 0. if_full_o = 0 (it is a function of count).
- if_full_o is combinational: count >= DEPTH-1.
- Pre-decode at push, stored as bit mem:
  - I-format: mem = 1 if opcode[6:0] is 0000011 (load) or 0100011 (store).
  - C-format: mem = 1 if ins[1:0]=00 with funct3[15:13] in {010, 110}, or ins[1:0]=10 with funct3 in {010, 110}.
  - All other instructions (ALU, branch, JAL, JALR): mem = 0.
- Push: at a clock edge with en=1 and if_en_i=1, the entry is written at tail and tail increments.
  - When count==DEPTH and no pop occurs in the same cycle, the push is dropped and state is unchanged.
- Issue condition, evaluated on current state: count>0, rob_full_i=0, and either (mem=1 and lsb_full_i=0) or (mem=0 and rs_full_i=0).
  - When the condition holds at an edge with en=1: head increments, dec_en_o<=1, and dec_* are loaded from the head entry.
  - Otherwise dec_en_o<=0 and dec_* hold their previous values.
- Latency: an entry pushed at edge T issues at edge T+1 at the earliest. dec_en_o is then high in cycle T+1..T+2. Empty-queue bypass is not supported.
- Throughput: one instruction per cycle while resources are free. Issue is strictly in order; a blocked head blocks all younger entries.
- Simultaneous push and pop: count is unchanged. This is legal at count==DEPTH, where the push is accepted. At count==0 the push is accepted and no pop occurs.
- Flush, at an edge with en=1 and flush_i=1 (has priority over push and issue):
  - head = tail = count = 0 and dec_en_o <= 0.
  - Any push and any issue in that cycle are discarded.
  - dec_ic_o, dec_ins_o, dec_pc_o and dec_pbr_o hold their values.
- en=0: no state changes, and flush_i and if_en_i are ignored. dec_en_o is forced 0 combinationally, so no duplicate issue occurs during a stall.
- Reset mid-operation clears all state immediately, regardless of clk.

Test Plan:
- Reset then push 3 I-ins (ADDI at PC 0x0, 0x4, 0x8; all full flags 0) -> dec_en_o high for 3 consecutive cycles starting 1 cycle after the first push; dec_pc_o = 0x0, 0x4, 0x8.
- Head LW (0x00002083), rs_full_i=1, lsb_full_i=0 -> issues. Then head ADD with rs_full_i=1 -> dec_en_o=0 until rs_full_i drops; the LW behind the ADD is not issued early.
- Push 16 entries with all resources full -> if_full_o rises when count=15. The 17th push is dropped. On release, exactly 16 issues occur in order and wrap is correct.
- C.LW (0x4108, ic=1) at head with lsb_full_i=1, rs_full_i=0 -> no issue. C.ADDI (0x0505) at head with lsb_full_i=1 -> issues.
- Queue holding 5 entries; flush_i=1 together with if_en_i=1 -> next cycle count=0, dec_en_o=0, if_full_o=0. The pushed instruction is never issued.
- en=0 for 3 cycles with a non-empty queue and free resources -> dec_en_o=0 and count unchanged. Issue resumes on the first cycle with en=1.
